// File: rtl/utils_pkg.sv
// Shared packet datapath types plus a reusable round-robin pick helper
// for push- and pop-side schedulers.
package utils_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_BODY = 3'd2,
    ST_TAIL = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0]  header;
    state_t      m_state;
    logic [20:0] payload;
  } packet_t;

  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  typedef struct packed {
    logic                 vld;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of mask at or after ptr, wrapping modulo n (n <= ARB_MAX_REQ, ptr < n).
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_REQ-1:0] mask,
                                       input logic [ARB_IDX_W-1:0]   ptr,
                                       input int                     n);
    rr_pick_t           r;
    logic [ARB_IDX_W:0] j;
    r = '0;
    // Walk offsets high to low so the smallest offset from ptr wins.
    for (int k = ARB_MAX_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (ARB_IDX_W + 1)'(k);
      if (j >= (ARB_IDX_W + 1)'(n)) j = j - (ARB_IDX_W + 1)'(n);
      if ((k < n) && mask[j[ARB_IDX_W-1:0]]) begin
        r.vld = 1'b1;
        r.idx = j[ARB_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr.sv
// Combinational round-robin selection among valid requesters starting at rr_ptr.
module rr_priority_select
  import utils_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic                       grant_vld,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [ARB_MAX_REQ-1:0] mask;
  rr_pick_t               sel;

  always_comb begin
    mask                = '0;
    mask[NUM_REQ-1:0]   = req_valid;
    sel                 = rr_pick(mask, ARB_IDX_W'(rr_ptr), NUM_REQ);
  end

  assign grant_vld = sel.vld;
  assign winner    = PTR_W'(sel.idx);

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter feeding the single push port of generic_fifo; a credit
// counter (occupancy) covers the one-cycle registered push latency.
module fifo_push_arbiter
  import utils_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 16,
  parameter int COUNT_SIZE = (DEPTH == 0) ? 1 : $clog2(DEPTH)
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  packet_t                    req_packet [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fifo_push,
  output packet_t                    fifo_data_in,
  input  logic                       fifo_pop,
  input  logic                       fifo_empty,
  output logic [COUNT_SIZE:0]        occupancy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int                  PTR_W    = $clog2(NUM_REQ);
  localparam logic [COUNT_SIZE:0] FULL_LVL = (COUNT_SIZE + 1)'(DEPTH);
  localparam logic [PTR_W-1:0]    LAST_REQ = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             grant_vld;
  logic             accept;
  logic             pop_ok;

  rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_vld (grant_vld),
    .winner    (winner)
  );

  // Acceptance stage: credit comes only from the registered counter, so a
  // same-cycle pop cannot reopen the grant.
  assign accept = grant_vld & (occupancy < FULL_LVL) & ~reset;
  assign pop_ok = fifo_pop & ~fifo_empty & (occupancy != '0);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Push stage: winner's packet registered toward the FIFO one cycle after grant.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      fifo_push    <= 1'b0;
      fifo_data_in <= '0;
      occupancy    <= '0;
    end else begin
      fifo_push <= accept;
      if (accept) begin
        rr_ptr       <= (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
        grant_id     <= winner;
        fifo_data_in <= req_packet[winner];
      end
      case ({accept, pop_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with a queue model of generic_fifo.
module tb_fifo_push_arbiter;
  import utils_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DEPTH   = 16;
  localparam int CS      = $clog2(DEPTH);

  logic               aclk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  packet_t            req_packet [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  logic               fifo_push;
  packet_t            fifo_data_in;
  logic               fifo_pop = 1'b0;
  logic               fifo_empty;
  logic [CS:0]        occupancy;
  logic [1:0]         grant_id;

  logic    empty_drv   = 1'b1;
  logic    use_model   = 1'b0;
  logic    model_empty = 1'b1;
  packet_t mq [$];
  packet_t popped [$];

  int errors = 0;
  int checks = 0;

  assign fifo_empty = use_model ? model_empty : empty_drv;

  always #5 aclk = ~aclk;

  fifo_push_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_packet   (req_packet),
    .req_ready    (req_ready),
    .fifo_push    (fifo_push),
    .fifo_data_in (fifo_data_in),
    .fifo_pop     (fifo_pop),
    .fifo_empty   (fifo_empty),
    .occupancy    (occupancy),
    .grant_id     (grant_id)
  );

  // generic_fifo stand-in: pop before push, both sampled at the edge.
  always @(posedge aclk) begin
    if (reset) begin
      mq.delete();
      model_empty <= 1'b1;
    end else if (use_model) begin
      if (fifo_pop && mq.size() > 0) popped.push_back(mq.pop_front());
      if (fifo_push) mq.push_back(fifo_data_in);
      model_empty <= (mq.size() == 0);
    end
  end

  function automatic packet_t mk(input logic [7:0] h, input state_t s, input logic [20:0] p);
    packet_t r;
    r.header  = h;
    r.m_state = s;
    r.payload = p;
    return r;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    fifo_pop  = 1'b0;
    empty_drv = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_packet[i] = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", fifo_push); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    checks++; if (fifo_data_in !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", fifo_data_in); end
    req_valid = '0;
    reset     = 1'b0;
  endtask

  task automatic test_single();
    packet_t p [3];
    do_reset();
    for (int i = 0; i < 3; i++) p[i] = mk(8'hFF, ST_BODY, 21'(i + 1));
    req_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      req_packet[2] = p[i];
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready%0d: got %b want 0100", i, req_ready); end
      tick();
      checks++; if (fifo_push !== 1'b1 || fifo_data_in !== p[i]) begin errors++; $display("FAIL single_push%0d: push=%b data=%h want 1 %h", i, fifo_push, fifo_data_in, p[i]); end
      checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid%0d: got %0d want 2", i, grant_id); end
    end
    req_valid = '0;
    checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL single_occ: got %0d want 3", occupancy); end
    tick();
    checks++; if (fifo_push !== 1'b0 || fifo_data_in !== p[2]) begin errors++; $display("FAIL single_idle: push=%b data=%h want 0 %h", fifo_push, fifo_data_in, p[2]); end
  endtask

  task automatic test_fairness();
    int e;
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) req_packet[r] = mk(8'(r), ST_HDR, 21'(100 + r));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      e = i % NUM_REQ;
      #1;
      checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", i, req_ready, 4'(1 << e)); end
      tick();
      checks++; if (grant_id !== 2'(e) || fifo_data_in !== req_packet[e]) begin errors++; $display("FAIL rr_grant%0d: gid=%0d data=%h want %0d %h", i, grant_id, fifo_data_in, e, req_packet[e]); end
    end
    req_valid = '0;
    checks++; if (occupancy !== 5'd8) begin errors++; $display("FAIL rr_occ: got %0d want 8", occupancy); end
  endtask

  task automatic test_full();
    int acc = 0;
    do_reset();
    req_packet[0] = mk(8'h10, ST_IDLE, 21'd7);
    req_valid     = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[0]) acc++;
      tick();
    end
    checks++; if (acc != 16) begin errors++; $display("FAIL full_accepts: got %0d want 16", acc); end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ: got %0d want 16", occupancy); end
    fifo_pop  = 1'b1;
    empty_drv = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_comb: got %b want 0000", req_ready); end
    tick();
    fifo_pop = 1'b0;
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL full_after_pop: got %0d want 15", occupancy); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_regrant: got %b want 0001", req_ready); end
    tick();
    checks++; if (occupancy !== 5'd16 || fifo_push !== 1'b1) begin errors++; $display("FAIL full_refill: occ=%0d push=%b want 16 1", occupancy, fifo_push); end
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_block: got %b want 0000", req_ready); end
    tick();
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL full_nopush: got %b want 0", fifo_push); end
    req_valid = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_packet[1] = mk(8'h21, ST_TAIL, 21'd5);
    req_valid     = 4'b0010;
    for (int c = 0; c < 5; c++) tick();
    checks++; if (occupancy !== 5'd5) begin errors++; $display("FAIL sim_fill: got %0d want 5", occupancy); end
    fifo_pop  = 1'b1;
    empty_drv = 1'b0;
    tick();
    checks++; if (occupancy !== 5'd5 || fifo_push !== 1'b1) begin errors++; $display("FAIL sim_both: occ=%0d push=%b want 5 1", occupancy, fifo_push); end
    req_valid = '0;
    empty_drv = 1'b1;
    tick();
    checks++; if (occupancy !== 5'd5) begin errors++; $display("FAIL sim_pop_empty: got %0d want 5", occupancy); end
    do_reset();
    fifo_pop = 1'b1;
    tick();
    tick();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL sim_underflow: got %0d want 0", occupancy); end
    fifo_pop = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_packet[2] = mk(8'h33, ST_BODY, 21'd9);
    req_valid     = 4'b0100;
    for (int c = 0; c < 7; c++) tick();
    req_valid = '0;
    checks++; if (occupancy !== 5'd7 || fifo_push !== 1'b1) begin errors++; $display("FAIL ar_pre: occ=%0d push=%b want 7 1", occupancy, fifo_push); end
    #2;
    req_valid = 4'b1111;
    reset     = 1'b1;
    #1;
    checks++; if (fifo_push !== 1'b0 || occupancy !== '0 || grant_id !== 2'd0 || fifo_data_in !== '0 || req_ready !== '0) begin
      errors++; $display("FAIL ar_async: push=%b occ=%0d gid=%0d data=%h rdy=%b want all 0", fifo_push, occupancy, grant_id, fifo_data_in, req_ready);
    end
    tick();
    reset     = 1'b0;
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ar_ptr0: got %b want 0001", req_ready); end
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ar_ptr3: got %b want 1000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_stream();
    packet_t pk [3][6];
    int      idx [3];
    int      k [3];
    int      cyc;
    int      r;
    logic [NUM_REQ-1:0] g;
    do_reset();
    use_model = 1'b1;
    popped.delete();
    for (int a = 0; a < 3; a++) begin
      idx[a] = 0;
      k[a]   = 0;
      for (int s = 0; s < 6; s++)
        pk[a][s] = mk(8'hA0 + 8'(a), state_t'($urandom_range(0, 4)), 21'(a * 16 + s));
    end
    cyc = 0;
    while (popped.size() < 18 && cyc < 600) begin
      for (int a = 0; a < 3; a++) begin
        req_valid[a] = (idx[a] < 6);
        if (idx[a] < 6) req_packet[a] = pk[a][idx[a]];
      end
      fifo_pop = (idx[0] == 6 && idx[1] == 6 && idx[2] == 6) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      g = req_ready & req_valid;
      tick();
      for (int a = 0; a < 3; a++) if (g[a]) idx[a]++;
      cyc++;
    end
    req_valid = '0;
    fifo_pop  = 1'b0;
    checks++; if (popped.size() != 18) begin errors++; $display("FAIL stream_count: got %0d want 18", popped.size()); end
    foreach (popped[j]) begin
      r = int'(popped[j].payload[5:4]);
      checks++;
      if (r > 2 || k[r] >= 6) begin
        errors++; $display("FAIL stream_src%0d: bad packet %h", j, popped[j]);
      end else begin
        if (popped[j] !== pk[r][k[r]]) begin errors++; $display("FAIL stream_order%0d: got %h want %h", j, popped[j], pk[r][k[r]]); end
        k[r]++;
      end
    end
    for (int a = 0; a < 3; a++) begin
      checks++; if (k[a] != 6) begin errors++; $display("FAIL stream_req%0d: popped %0d want 6", a, k[a]); end
    end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL stream_occ: got %0d want 0", occupancy); end
    use_model = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_simultaneous();
    test_async_reset();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
